// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner and instruction fetch stage; req/ack to imem,
//               valid/ready to decode, redirect squashes younger fetches.
//               Optional macro MISALIGN_TRAP_EN enables misaligned-target trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            o_misaligned
`endif
);

    localparam logic [31:0]     c_nop     = 32'h0000_0013;
    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
`ifdef MISALIGN_TRAP_EN
        ,
        S_TRAP = 2'd3
`endif
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_addr;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_valid;

    logic [XLEN-1:0] w_target;
    state_t          w_redir_state;
    state_t          w_drop_state;

`ifdef MISALIGN_TRAP_EN
    logic w_target_bad;
    logic r_trap_pend;

    assign w_target      = i_redirect_pc;
    assign w_target_bad  = |i_redirect_pc[1:0];
    assign w_redir_state = w_target_bad ? S_TRAP : S_REQ;
    // Trap is taken only once the request in flight at redirect time completes.
    assign w_drop_state  = r_trap_pend ? S_TRAP : S_REQ;
    assign o_misaligned  = (r_state == S_TRAP);
`else
    logic w_unused_lsbs;

    assign w_target      = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_lsbs = ^i_redirect_pc[1:0];
    assign w_redir_state = S_REQ;
    assign w_drop_state  = S_REQ;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_instr    <= c_nop;
            r_instr_pc <= RESET_PC;
            r_valid    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_trap_pend <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            if (i_redirect) begin
                r_trap_pend <= w_target_bad;
            end
`endif
            case (r_state)
                S_REQ: begin
                    if (i_redirect) begin
                        r_pc <= w_target;
                        if (i_imem_ack) begin
                            r_req_addr <= w_target;
                            r_state    <= w_redir_state;
                        end else begin
                            // Memory still owes us this word; keep the address stable.
                            r_state <= S_DROP;
                        end
                    end else if (i_imem_ack) begin
                        r_instr    <= i_imem_rdata;
                        r_instr_pc <= r_req_addr;
                        r_valid    <= 1'b1;
                        r_pc       <= r_req_addr + c_pc_step;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_redirect) begin
                        r_pc       <= w_target;
                        r_req_addr <= w_target;
                        r_valid    <= 1'b0;
                        r_state    <= w_redir_state;
                    end else if (r_valid && i_instr_ready) begin
                        r_valid    <= 1'b0;
                        r_req_addr <= r_pc;
                        r_state    <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (i_redirect) begin
                        r_pc <= w_target;
                        if (i_imem_ack) begin
                            r_req_addr <= w_target;
                            r_state    <= w_redir_state;
                        end
                    end else if (i_imem_ack) begin
                        r_req_addr <= r_pc;
                        r_state    <= w_drop_state;
                    end
                end
`ifdef MISALIGN_TRAP_EN
                S_TRAP: begin
                    if (i_redirect && !w_target_bad) begin
                        r_pc       <= w_target;
                        r_req_addr <= w_target;
                        r_state    <= S_REQ;
                    end
                end
`endif
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    assign o_imem_req    = ((r_state == S_REQ) || (r_state == S_DROP)) && !i_rst;
    assign o_imem_addr   = r_req_addr;
    assign o_instr_valid = r_valid & ~i_redirect;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_opcode      = r_instr[6:0];
    assign o_funct3      = r_instr[14:12];
    assign o_funct7      = r_instr[31:25];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed bench for instr_fetch_unit with a small imem model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int checks   = 0;
    int failures = 0;
    int mem_delay = 0;
    int wait_cnt  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } vec_t;

    vec_t vec[5];

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (imem_ack),
        .i_imem_rdata  (imem_rdata),
        .o_instr_valid (instr_valid),
        .i_instr_ready (ready),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_opcode      (opcode),
        .o_funct3      (funct3),
        .o_funct7      (funct7),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc)
`ifdef MISALIGN_TRAP_EN
        ,
        .o_misaligned  (misaligned)
`endif
    );

    always #5 clk = ~clk;

    // Table words at their addresses; elsewhere an addi whose immediate is addr[11:0].
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[11:0], 20'h00013};
        for (int i = 0; i < 5; i++) begin
            if (vec[i].addr == a) w = vec[i].word;
        end
        return w;
    endfunction

    // Memory answers after mem_delay waiting cycles, deciding just after each falling edge.
    always @(negedge clk) begin
        #1;
        if (imem_req) begin
            if (wait_cnt >= mem_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                wait_cnt   = wait_cnt + 1;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_valid(input string name, input logic [31:0] w, input logic [31:0] pc);
        chk({name, " valid"}, instr_valid, 1);
        chk({name, " instr"}, instr, w);
        chk({name, " pc"}, instr_pc, pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{32'h0000_0000, 32'h0050_0093, 7'h13, 3'd0, 7'h00};
        vec[1] = '{32'h0000_0004, 32'h4020_8133, 7'h33, 3'd0, 7'h20};
        vec[2] = '{32'h0000_0008, 32'h0020_A023, 7'h23, 3'd2, 7'h00};
        vec[3] = '{32'h0000_000C, 32'hFE20_9EE3, 7'h63, 3'd1, 7'h7F};
        vec[4] = '{32'h0000_0010, 32'h0000_C0B7, 7'h37, 3'd4, 7'h00};

        rst = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst req", imem_req, 0);
        chk("rst addr", imem_addr, 0);
        chk("rst valid", instr_valid, 0);
        chk("rst instr", instr, 32'h13);
        chk("rst pc", instr_pc, 0);
`ifdef MISALIGN_TRAP_EN
        chk("rst misaligned", misaligned, 0);
`endif
        rst = 1'b0;
        #1;

        // Zero-wait sequential fetch: request cycle, then valid cycle, accepted at once.
        for (int i = 0; i < 5; i++) begin
            chk("seq req", imem_req, 1);
            chk("seq addr", imem_addr, vec[i].addr);
            @(negedge clk);
            chk_valid("seq", vec[i].word, vec[i].addr);
            chk("seq opcode", opcode, vec[i].opc);
            chk("seq funct3", funct3, vec[i].f3);
            chk("seq funct7", funct7, vec[i].f7);
            chk("seq hold req", imem_req, 0);
            @(negedge clk);
        end

        // Decode stalls for 5 cycles.
        chk("stall req", imem_req, 1);
        chk("stall addr", imem_addr, 32'h14);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_valid("stall", 32'h0140_0013, 32'h14);
            chk("stall no req", imem_req, 0);
        end
        ready = 1'b1;
        mem_delay = 3;

        // Ack arrives in the fourth request cycle.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wait req", imem_req, 1);
            chk("wait addr", imem_addr, 32'h18);
            chk("wait valid", instr_valid, 0);
        end
        @(negedge clk);
        chk_valid("wait", 32'h0180_0013, 32'h18);

        // Redirect while request outstanding: old data dropped.
        @(negedge clk);
        chk("drop addr0", imem_addr, 32'h1C);
        redirect = 1'b1; redirect_pc = 32'h100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            redirect = 1'b0;
            chk("drop req", imem_req, 1);
            chk("drop addr", imem_addr, 32'h1C);
            chk("drop valid", instr_valid, 0);
        end
        @(negedge clk);
        chk("drop new req", imem_req, 1);
        chk("drop new addr", imem_addr, 32'h100);
        chk("drop new valid", instr_valid, 0);
        mem_delay = 0;
        @(negedge clk);
        chk_valid("tgt100", 32'h1000_0013, 32'h100);

        // Redirect in hold with ready high: squashed instruction never handshakes.
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("hold squash valid", instr_valid, 0);
        @(negedge clk);
        redirect = 1'b0;
        chk("hold redir req", imem_req, 1);
        chk("hold redir addr", imem_addr, 32'h40);
        @(negedge clk);
        chk_valid("tgt40", 32'h0400_0013, 32'h40);

        // Redirect coinciding with ack.
        @(negedge clk);
        chk("ackredir addr0", imem_addr, 32'h44);
        redirect = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        redirect = 1'b0;
        chk("ackredir req", imem_req, 1);
        chk("ackredir addr", imem_addr, 32'h80);
        chk("ackredir valid", instr_valid, 0);
        @(negedge clk);
        chk_valid("tgt80", 32'h0800_0013, 32'h80);

        // PC wraps past the top of the address space.
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        chk("wrap addr0", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk_valid("wrap", 32'hFFC0_0013, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap req", imem_req, 1);
        chk("wrap addr", imem_addr, 32'h0);

        // Misaligned redirect target.
        redirect = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
`ifdef MISALIGN_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            chk("trap misaligned", misaligned, 1);
            chk("trap req", imem_req, 0);
            chk("trap valid", instr_valid, 0);
            @(negedge clk);
        end
        redirect = 1'b1; redirect_pc = 32'h200;
        mem_delay = 5;
        @(negedge clk);
        redirect = 1'b0;
        chk("untrap misaligned", misaligned, 0);
        chk("untrap req", imem_req, 1);
        chk("untrap addr", imem_addr, 32'h200);
        @(negedge clk);
        chk("untrap wait addr", imem_addr, 32'h200);
`else
        chk("align req", imem_req, 1);
        chk("align addr", imem_addr, 32'h100);
        @(negedge clk);
        chk_valid("align", 32'h1000_0013, 32'h100);
        mem_delay = 5;
        @(negedge clk);
        chk("pre-rst addr", imem_addr, 32'h104);
        @(negedge clk);
        chk("pre-rst wait req", imem_req, 1);
`endif

        // Reset while a request is outstanding.
        rst = 1'b1;
        #1;
        chk("midrst req", imem_req, 0);
        @(negedge clk);
        chk("midrst valid", instr_valid, 0);
        chk("midrst addr", imem_addr, 0);
        chk("midrst instr", instr, 32'h13);
        rst = 1'b0;
        mem_delay = 0;
        #1;
        chk("postrst req", imem_req, 1);
        chk("postrst addr", imem_addr, 0);
        @(negedge clk);
        chk_valid("postrst", 32'h0050_0093, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that drives the instruction stream into the control unit and register/immediate logic. It owns the program counter, issues word requests to instruction memory over a req/ack handshake, and presents each fetched instruction with its PC and pre-split opcode/funct3/funct7 fields to decode over a valid/ready handshake. Taken branches and jumps resolved downstream redirect the PC and squash any younger fetch in progress.

## Interface
Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset; synchronous, active-high
- o_imem_req  out  1  fetch request; held high until i_imem_ack
- o_imem_addr  out  XLEN  word address of the request; stable while o_imem_req high
- i_imem_ack  in  1  single-cycle acknowledge; may arrive in the same cycle as o_imem_req
- i_imem_rdata  in  32  instruction word; valid only when i_imem_ack=1
- o_instr_valid  out  1  instruction available to decode
- i_instr_ready  in  1  decode accepts the instruction
- o_instr  out  32  instruction word
- o_instr_pc  out  XLEN  address of o_instr
- o_opcode  out  OPCODE (7)  o_instr[6:0]
- o_funct3  out  FUNCT3 (3)  o_instr[14:12]
- o_funct7  out  FUNCT7 (7)  o_instr[31:25]
- i_redirect  in  1  taken branch/jump; pulse
- i_redirect_pc  in  XLEN  redirect target
- o_misaligned  out  1  misaligned redirect target (present only with MISALIGN_TRAP_EN)

## Operation
- Registers: pc (next fetch address), req_addr, instr_q, instr_pc_q, valid_q.
- States: S_REQ, S_HOLD, S_DROP, S_TRAP (S_TRAP only with macro).
- S_REQ: o_imem_req=1, o_imem_addr=req_addr. On i_imem_ack: instr_q<=i_imem_rdata, instr_pc_q<=req_addr, valid_q<=1, pc<=req_addr+4 (mod 2^XLEN, wraps to 0), -> S_HOLD.
- S_HOLD: o_imem_req=0. On o_instr_valid & i_instr_ready: valid_q<=0, req_addr<=pc, -> S_REQ.
- S_DROP: o_imem_req=1 with old req_addr; on i_imem_ack discard data, req_addr<=pc, -> S_REQ.
- Redirect (highest priority, any state): pc<=req_addr<=i_redirect_pc, valid_q<=0.
  - S_REQ without ack same cycle: -> S_DROP (outstanding request completed, data discarded); req_addr updated only on leaving S_DROP.
  - S_REQ with ack same cycle: data discarded, -> S_REQ at target.
  - S_HOLD: held instruction squashed; -> S_REQ at target.
  - S_DROP: retarget pc only; remain in S_DROP.
- o_instr_valid = valid_q & ~i_redirect (a squashed instruction never handshakes).
- Field outputs are combinational slices of instr_q.

## Timing
- Reset values: o_imem_req=0, o_imem_addr=RESET_PC, o_instr_valid=0, o_instr=32'h0000_0013 (NOP), o_instr_pc=RESET_PC, o_misaligned=0, state=S_REQ.
- First cycle after i_rst falls: o_imem_req=1, addr=RESET_PC.
- Ack in request cycle N -> o_instr_valid high cycle N+1.
- Accept in cycle M -> next request cycle M+1; peak throughput 1 instruction / 2 cycles with zero-wait memory.
- Redirect cycle R (S_HOLD or S_REQ+ack) -> request to target in cycle R+1.
- Reset mid-operation: outstanding request abandoned; memory must tolerate req dropping.

## Configuration
- MISALIGN_TRAP_EN defined: redirect with i_redirect_pc[1:0]!=0 -> pending request completed/discarded as above, then S_TRAP: o_imem_req=0, o_instr_valid=0, o_misaligned=1 held until i_rst or an aligned redirect (-> S_REQ at that target).
- Undefined: i_redirect_pc[1:0] forced to 2'b00; o_misaligned port absent; no S_TRAP.

## Test plan
- Reset, zero-wait memory returning 0x00500093 at 0x0, ready=1 -> req at 0x0 first cycle, valid next cycle, o_opcode=7'h13, o_funct3=0, o_instr_pc=0; next req addr 0x4.
- ready=0 for 5 cycles -> o_instr/o_instr_pc stable, o_imem_req=0 throughout; no refetch.
- Ack delayed 3 cycles -> o_imem_addr stable, req high each cycle, single valid after ack.
- Redirect to 0x100 while request at 0x8 outstanding, ack 2 cycles later -> data for 0x8 never valid; next request addr 0x100.
- Redirect to 0x40 in S_HOLD with ready=1 same cycle -> o_instr_valid=0 that cycle; next request 0x40.
- MISALIGN_TRAP_EN: redirect to 0x102 -> o_misaligned=1, no further requests; redirect to 0x200 -> o_misaligned=0, request 0x200. Without macro: request 0x100.
